// File: rtl/entry_arb_pkg.sv
// Shared types and defaults for the two-requester entry arbiter.
// Holds state and side encodings plus the default sizing.
package entry_arb_pkg;

  localparam int DW_DEF      = 4;
  localparam int TIMEOUT_DEF = 8;
  localparam int TW_DEF      = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_t;

  function automatic side_t other_side(input side_t s);
    return (s == SIDE_L) ? SIDE_R : SIDE_L;
  endfunction

endpackage

// File: rtl/entry_arbiter_if.sv
// Requester-facing and shared-datapath signals of the entry arbiter.
// The arbiter uses the slave modport; the requesters use master.
interface entry_arbiter_if #(
  parameter int DW = 4
);

  logic          req_l;
  logic          req_r;
  logic [DW-1:0] din_l;
  logic [DW-1:0] din_r;
  logic          confirm_l;
  logic          confirm_r;
  logic          grant_l;
  logic          grant_r;
  logic          sys_req;
  logic [DW-1:0] sys_din;
  logic          sys_confirm;
  logic [DW-1:0] dout_left;
  logic [DW-1:0] dout_right;
  logic          busy;
  logic          timeout_err;

  modport master (
    output req_l, req_r, din_l, din_r, confirm_l, confirm_r,
    input  grant_l, grant_r, sys_req, sys_din, sys_confirm,
           dout_left, dout_right, busy, timeout_err
  );

  modport slave (
    input  req_l, req_r, din_l, din_r, confirm_l, confirm_r,
    output grant_l, grant_r, sys_req, sys_din, sys_confirm,
           dout_left, dout_right, busy, timeout_err
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector.
// A lone request always wins; a tie goes to the side named by ptr.
module rr_pick2
  import entry_arb_pkg::*;
(
  input  logic  req_l,
  input  logic  req_r,
  input  side_t ptr,
  output logic  valid,
  output side_t side
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    valid = req_l | req_r;
    side  = ptr;
    if (req_l && !req_r) begin
      side = SIDE_L;
    end else if (req_r && !req_l) begin
      side = SIDE_R;
    end
  end

endmodule

// File: rtl/entry_arbiter.sv
// Two-requester arbiter/sequencer for the shared entry datapath:
// grants one side at a time, forwards its req/din/confirm, commits its value.
module entry_arbiter
  import entry_arb_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  entry_arbiter_if.slave bus
);

  state_t        state_q, state_d;
  side_t         side_q, side_d;
  side_t         ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tmo_q, tmo_d;
  logic          commit_l, commit_r;
  logic [DW-1:0] dout_l_q, dout_r_q;
  logic          pick_valid;
  side_t         pick_side;
  logic          req_g, confirm_g;
  logic [DW-1:0] din_g;
  logic          busy;

  rr_pick2 u_pick (
    .req_l (bus.req_l),
    .req_r (bus.req_r),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .side  (pick_side)
  );

  // Everything the granted side presents is muxed off the registered grant.
  assign req_g     = (side_q == SIDE_L) ? bus.req_l     : bus.req_r;
  assign confirm_g = (side_q == SIDE_L) ? bus.confirm_l : bus.confirm_r;
  assign din_g     = (side_q == SIDE_L) ? bus.din_l     : bus.din_r;

  always_comb begin
    state_d  = state_q;
    side_d   = side_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    tmo_d    = 1'b0;
    commit_l = 1'b0;
    commit_r = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_WAIT;
          side_d  = pick_side;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        // Abort beats confirm, and confirm beats the timeout.
        if (!req_g) begin
          state_d = S_IDLE;
        end else if (confirm_g) begin
          state_d  = S_COMMIT;
          commit_l = (side_q == SIDE_L);
          commit_r = (side_q == SIDE_R);
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
          ptr_d   = other_side(side_q);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        ptr_d   = other_side(side_q);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all state so every register sees pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      side_q   <= SIDE_L;
      ptr_q    <= SIDE_L;
      timer_q  <= '0;
      tmo_q    <= 1'b0;
      dout_l_q <= '0;
      dout_r_q <= '0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      tmo_q   <= tmo_d;
      if (commit_l) dout_l_q <= bus.din_l;
      if (commit_r) dout_r_q <= bus.din_r;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign bus.busy        = busy;
  assign bus.grant_l     = busy && (side_q == SIDE_L);
  assign bus.grant_r     = busy && (side_q == SIDE_R);
  assign bus.sys_req     = busy;
  assign bus.sys_din     = busy ? din_g : '0;
  assign bus.sys_confirm = (state_q == S_COMMIT);
  assign bus.dout_left   = dout_l_q;
  assign bus.dout_right  = dout_r_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_entry_arbiter.sv
// Directed bench for entry_arbiter: inputs change and outputs are checked
// on the falling edge, each scenario in its own task.
module tb_entry_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  entry_arbiter_if #(.DW(4)) bus ();

  entry_arbiter #(.DW(4), .TIMEOUT(8), .TW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {grant_l, grant_r, busy, sys_req, sys_confirm, timeout_err}
  wire [5:0] flags = {bus.grant_l, bus.grant_r, bus.busy, bus.sys_req,
                      bus.sys_confirm, bus.timeout_err};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL reset_flags: got %b expected %b", flags, 6'b000000); end
    vectors++; if (bus.sys_din !== 4'h0) begin miscompares++; $display("FAIL reset_sys_din: got %h expected %h", bus.sys_din, 4'h0); end
    vectors++; if (bus.dout_left !== 4'h0) begin miscompares++; $display("FAIL reset_dout_left: got %h expected %h", bus.dout_left, 4'h0); end
    vectors++; if (bus.dout_right !== 4'h0) begin miscompares++; $display("FAIL reset_dout_right: got %h expected %h", bus.dout_right, 4'h0); end
    rst = 1'b0;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL reset_idle: got %b expected %b", flags, 6'b000000); end
  endtask

  task automatic test_single_commit();
    bus.req_l = 1'b1; bus.din_l = 4'b0011;
    step();
    vectors++; if (flags !== 6'b101100) begin miscompares++; $display("FAIL single_grant: got %b expected %b", flags, 6'b101100); end
    vectors++; if (bus.sys_din !== 4'b0011) begin miscompares++; $display("FAIL single_sys_din: got %h expected %h", bus.sys_din, 4'b0011); end
    bus.confirm_l = 1'b1;
    step();
    vectors++; if (flags !== 6'b101110) begin miscompares++; $display("FAIL single_commit: got %b expected %b", flags, 6'b101110); end
    vectors++; if (bus.dout_left !== 4'b0011) begin miscompares++; $display("FAIL single_dout_left: got %h expected %h", bus.dout_left, 4'b0011); end
    vectors++; if (bus.dout_right !== 4'h0) begin miscompares++; $display("FAIL single_dout_right: got %h expected %h", bus.dout_right, 4'h0); end
    bus.req_l = 1'b0; bus.confirm_l = 1'b0;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL single_release: got %b expected %b", flags, 6'b000000); end
    vectors++; if (bus.dout_left !== 4'b0011) begin miscompares++; $display("FAIL single_hold: got %h expected %h", bus.dout_left, 4'b0011); end
  endtask

  task automatic test_tie();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_l = 1'b1; bus.req_r = 1'b1; bus.din_l = 4'b0101; bus.din_r = 4'b0100;
    step();
    vectors++; if (flags !== 6'b101100) begin miscompares++; $display("FAIL tie_first_left: got %b expected %b", flags, 6'b101100); end
    vectors++; if (bus.sys_din !== 4'b0101) begin miscompares++; $display("FAIL tie_sys_din_l: got %h expected %h", bus.sys_din, 4'b0101); end
    bus.confirm_l = 1'b1;
    step();
    vectors++; if (flags !== 6'b101110) begin miscompares++; $display("FAIL tie_commit_l: got %b expected %b", flags, 6'b101110); end
    vectors++; if (bus.dout_left !== 4'b0101) begin miscompares++; $display("FAIL tie_dout_left: got %h expected %h", bus.dout_left, 4'b0101); end
    bus.confirm_l = 1'b0;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL tie_gap: got %b expected %b", flags, 6'b000000); end
    step();
    vectors++; if (flags !== 6'b011100) begin miscompares++; $display("FAIL tie_then_right: got %b expected %b", flags, 6'b011100); end
    vectors++; if (bus.sys_din !== 4'b0100) begin miscompares++; $display("FAIL tie_sys_din_r: got %h expected %h", bus.sys_din, 4'b0100); end
    bus.req_l = 1'b0; bus.confirm_r = 1'b1;
    step();
    vectors++; if (flags !== 6'b011110) begin miscompares++; $display("FAIL tie_commit_r: got %b expected %b", flags, 6'b011110); end
    vectors++; if (bus.dout_right !== 4'b0100) begin miscompares++; $display("FAIL tie_dout_right: got %h expected %h", bus.dout_right, 4'b0100); end
    bus.req_r = 1'b0; bus.confirm_r = 1'b0;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL tie_release: got %b expected %b", flags, 6'b000000); end
  endtask

  task automatic test_timeout();
    // A left commit first leaves the pointer on the right.
    bus.req_l = 1'b1; bus.din_l = 4'hA;
    step();
    bus.confirm_l = 1'b1;
    step();
    vectors++; if (bus.dout_left !== 4'hA) begin miscompares++; $display("FAIL tmo_pre_commit: got %h expected %h", bus.dout_left, 4'hA); end
    bus.req_l = 1'b0; bus.confirm_l = 1'b0;
    step();
    bus.req_r = 1'b1; bus.din_r = 4'h9;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++; if (flags !== 6'b011100) begin miscompares++; $display("FAIL tmo_hold_%0d: got %b expected %b", i, flags, 6'b011100); end
    end
    step();
    vectors++; if (flags !== 6'b000001) begin miscompares++; $display("FAIL tmo_pulse: got %b expected %b", flags, 6'b000001); end
    vectors++; if (bus.dout_right !== 4'b0100) begin miscompares++; $display("FAIL tmo_dout_right: got %h expected %h", bus.dout_right, 4'b0100); end
    bus.req_r = 1'b0;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL tmo_pulse_end: got %b expected %b", flags, 6'b000000); end
    bus.req_l = 1'b1; bus.req_r = 1'b1;
    step();
    vectors++; if (flags !== 6'b101100) begin miscompares++; $display("FAIL tmo_next_tie_left: got %b expected %b", flags, 6'b101100); end
    bus.req_l = 1'b0; bus.req_r = 1'b0;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL tmo_abort_idle: got %b expected %b", flags, 6'b000000); end
  endtask

  task automatic test_abort();
    bus.req_l = 1'b1; bus.din_l = 4'h7;
    step();
    vectors++; if (flags !== 6'b101100) begin miscompares++; $display("FAIL abort_grant: got %b expected %b", flags, 6'b101100); end
    step();
    bus.req_l = 1'b0; bus.confirm_l = 1'b1; bus.confirm_r = 1'b1; bus.din_r = 4'hF;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL abort_idle: got %b expected %b", flags, 6'b000000); end
    vectors++; if (bus.dout_left !== 4'hA) begin miscompares++; $display("FAIL abort_dout_left: got %h expected %h", bus.dout_left, 4'hA); end
    vectors++; if (bus.dout_right !== 4'b0100) begin miscompares++; $display("FAIL abort_dout_right: got %h expected %h", bus.dout_right, 4'b0100); end
    bus.confirm_l = 1'b0; bus.confirm_r = 1'b0;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL abort_quiet: got %b expected %b", flags, 6'b000000); end
    bus.req_l = 1'b1; bus.req_r = 1'b1;
    step();
    vectors++; if (flags !== 6'b101100) begin miscompares++; $display("FAIL abort_ptr_kept: got %b expected %b", flags, 6'b101100); end
    bus.req_l = 1'b0; bus.req_r = 1'b0;
    step();
  endtask

  task automatic test_confirm_at_timeout();
    bus.req_l = 1'b1; bus.din_l = 4'hC;
    for (int i = 0; i < 7; i++) begin
      step();
    end
    step();
    vectors++; if (flags !== 6'b101100) begin miscompares++; $display("FAIL edge_last_wait: got %b expected %b", flags, 6'b101100); end
    bus.confirm_l = 1'b1;
    step();
    vectors++; if (flags !== 6'b101110) begin miscompares++; $display("FAIL edge_commit: got %b expected %b", flags, 6'b101110); end
    vectors++; if (bus.dout_left !== 4'hC) begin miscompares++; $display("FAIL edge_dout_left: got %h expected %h", bus.dout_left, 4'hC); end
    bus.req_l = 1'b0; bus.confirm_l = 1'b0;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL edge_no_error: got %b expected %b", flags, 6'b000000); end
  endtask

  task automatic test_reset_midway();
    bus.req_r = 1'b1;
    step();
    vectors++; if (flags !== 6'b011100) begin miscompares++; $display("FAIL rstw_grant: got %b expected %b", flags, 6'b011100); end
    rst = 1'b1; bus.confirm_r = 1'b1; bus.din_r = 4'h5;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL rstw_flags: got %b expected %b", flags, 6'b000000); end
    vectors++; if (bus.dout_right !== 4'h0) begin miscompares++; $display("FAIL rstw_dout_right: got %h expected %h", bus.dout_right, 4'h0); end
    vectors++; if (bus.dout_left !== 4'h0) begin miscompares++; $display("FAIL rstw_dout_left: got %h expected %h", bus.dout_left, 4'h0); end
    rst = 1'b0; bus.confirm_r = 1'b0;
    step();
    vectors++; if (flags !== 6'b011100) begin miscompares++; $display("FAIL rstw_regrant_r: got %b expected %b", flags, 6'b011100); end
    bus.req_r = 1'b0;
    step();
    bus.req_l = 1'b1; bus.din_l = 4'h6;
    step();
    bus.confirm_l = 1'b1;
    step();
    vectors++; if (flags !== 6'b101110) begin miscompares++; $display("FAIL rstc_commit: got %b expected %b", flags, 6'b101110); end
    vectors++; if (bus.dout_left !== 4'h6) begin miscompares++; $display("FAIL rstc_dout_left: got %h expected %h", bus.dout_left, 4'h6); end
    rst = 1'b1;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL rstc_flags: got %b expected %b", flags, 6'b000000); end
    vectors++; if (bus.dout_left !== 4'h0) begin miscompares++; $display("FAIL rstc_dout_left: got %h expected %h", bus.dout_left, 4'h0); end
    rst = 1'b0; bus.confirm_l = 1'b0; bus.req_r = 1'b1;
    step();
    vectors++; if (flags !== 6'b101100) begin miscompares++; $display("FAIL rstc_ptr_left: got %b expected %b", flags, 6'b101100); end
    bus.req_l = 1'b0; bus.req_r = 1'b0;
    step();
    vectors++; if (flags !== 6'b000000) begin miscompares++; $display("FAIL rstc_release: got %b expected %b", flags, 6'b000000); end
  endtask

  initial begin
    bus.req_l = 1'b0; bus.req_r = 1'b0;
    bus.din_l = 4'h0; bus.din_r = 4'h0;
    bus.confirm_l = 1'b0; bus.confirm_r = 1'b0;
    test_reset();
    test_single_commit();
    test_tie();
    test_timeout();
    test_abort();
    test_confirm_at_timeout();
    test_reset_midway();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/entry_arbiter.md
Name: entry_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 4-bit keypad/entry datapath (`system`: req, confirm, din → dout_left/dout_right).
- A left and a right requester each present req/din/confirm; the block grants one at a time with round-robin fairness.
- It drives the shared datapath's req/din/confirm on behalf of the granted side and commits the confirmed value into that side's output register.
- A confirm timeout prevents one side from holding the resource indefinitely.

Parameters:
- DW, 4, data width of din/dout.
- TIMEOUT, 8, number of WAIT cycles without confirm before the grant is revoked (≥2).
- TW, 4, width of the timeout counter (2^TW > TIMEOUT).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_l, req_r  in  1  request from the left / right requester (level).
- din_l, din_r  in  DW  data from the left / right requester.
- confirm_l, confirm_r  in  1  confirm from the left / right requester (level; sampled only while granted).
- grant_l, grant_r  out  1  one-hot grant (never both high).
- sys_req  out  1  request to the shared datapath; high in WAIT and COMMIT.
- sys_din  out  DW  granted side's din in WAIT/COMMIT; 0 otherwise.
- sys_confirm  out  1  high for exactly the one COMMIT cycle.
- dout_left, dout_right  out  DW  last committed value per side.
- busy  out  1  high when state != IDLE.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (synchronous, on rst=1 at a clk edge):
  - state=IDLE, priority pointer=LEFT, timer=0.
  - All outputs 0, including dout_left, dout_right, grant_*, timeout_err.
  - rst overrides everything, including mid-WAIT or COMMIT; no commit occurs in a reset cycle.
- State IDLE:
  - Only req_l high → WAIT, granted side L. Only req_r high → WAIT, side R.
  - Both high → the side named by the pointer wins.
  - Neither high → stay in IDLE.
  - grant_x rises the cycle after req_x is sampled (1-cycle grant latency); timer loads 0.
- State WAIT (granted side g), priority order:
  - (1) req_g low → IDLE. Silent abort: no commit, no error, pointer unchanged.
  - (2) confirm_g high → COMMIT. dout_g <= din_g, sampled at this edge and visible in the COMMIT cycle.
  - (3) timer == TIMEOUT-1 → IDLE. timeout_err pulses in the following cycle; pointer <= other side.
  - (4) otherwise timer <= timer+1.
  - din_g may change freely during WAIT; sys_din tracks it combinationally from the registered grant.
  - The non-granted side's confirm and din are ignored entirely.
- State COMMIT:
  - Lasts exactly 1 cycle: sys_confirm=1, grant held, busy=1.
  - Next state IDLE; pointer <= other side.
- Latencies:
  - Request to commit: minimum 2 cycles (req sampled → WAIT, confirm in first WAIT cycle → COMMIT).
  - The arbiter returns to IDLE for at least one cycle between grants, so grant_l→grant_r handover always has a 1-cycle gap.
- Fairness:
  - After a commit or timeout, the other side wins the next tie.
  - A side holding req high after its commit only regains the grant if the other side is idle.
- dout registers:
  - Hold their value indefinitely.
  - Change only on a WAIT→COMMIT transition for their own side, or on reset.
- Boundaries:
  - confirm_g and the timeout on the same edge → confirm wins (commit, no error).
  - req_g drop and confirm_g on the same edge → abort wins.
  - TIMEOUT counting: the grant is revoked after exactly TIMEOUT WAIT cycles.

Decomposition:
- Shared package `entry_arb_pkg`:
  - State encoding constants S_IDLE=2'd0, S_WAIT=2'd1, S_COMMIT=2'd2.
  - Side constants SIDE_L=1'b0, SIDE_R=1'b1.
  - Default DW/TIMEOUT.
- One natural sub-module, `rr_pick2`: combinational 2-way round-robin selector (req_l, req_r, ptr → valid, side).
- FSM, timer and output registers stay in `entry_arbiter`.

Test Plan:
- Reset then req_l=1, din_l=4'b0011, confirm_l high on the 2nd cycle after req → grant_l at +1; sys_confirm pulse 1 cycle; dout_left=4'b0011; dout_right=0.
- req_l and req_r both raised in the same cycle after reset → grant_l first. After L commits 4'b0101, grant_r follows after a 1-cycle IDLE gap; R confirms 4'b0100 → dout_right=4'b0100.
- req_r=1, never confirm, TIMEOUT=8 → grant_r high exactly 8 cycles; timeout_err 1-cycle pulse; dout_right unchanged; next tie goes to L.
- Granted L drops req_l mid-WAIT while confirm_r=1 → return to IDLE, no commit, no timeout_err, dout_* unchanged, confirm_r ignored.
- rst=1 asserted during COMMIT (and separately during WAIT) → next edge: all outputs 0, state IDLE, pointer LEFT; subsequent req_r alone is granted normally.
- confirm_l rises on the same edge the timer reaches TIMEOUT-1 → commit occurs (dout_left updated), no timeout_err.
